cv32e40x_xif_aes_result_queue: RTL and testbench

In-order result queue between the AES functional unit and the XIF result interface. An entry is allocated for each accepted AES32 instruction. The queue captures the FU result, tracks commit/kill per instruction ID, and presents committed results on the result handshake in issue order. Killed instructions are discarded silently.

---
 rtl/cv32e40x_xif_aes_result_queue.sv | 181 ++++++++++++++++++
 tb/tb_cv32e40x_xif_aes_result_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_xif_aes_result_queue.sv
// rtl/cv32e40x_xif_aes_result_queue.sv - in-order AES result queue in front of the XIF result interface
//
// Purpose: holds one entry per accepted AES32 instruction. Each entry collects
// the FU result and the commit or kill for its ID. Committed results leave on
// the result handshake in issue order. Killed entries are dropped silently.
// Ports:
//   alloc_*   : allocation from the issue side (alloc_ready = room available)
//   fu_*      : single-cycle FU result strobe, no backpressure
//   commit_*  : XIF commit/kill strobe
//   result_*  : XIF result handshake (result_we mirrors result_valid)
//   count     : occupied entries; protocol_err: sticky misuse flag
module cv32e40x_xif_aes_result_queue #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [X_ID_WIDTH-1:0]        alloc_id,
    input  logic [4:0]                   alloc_rd,
    output logic                         alloc_ready,
    input  logic                         fu_valid,
    input  logic [X_ID_WIDTH-1:0]        fu_id,
    input  logic [X_RFW_WIDTH-1:0]       fu_data,
    input  logic                         commit_valid,
    input  logic [X_ID_WIDTH-1:0]        commit_id,
    input  logic                         commit_kill,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [X_ID_WIDTH-1:0]        result_id,
    output logic [X_RFW_WIDTH-1:0]       result_data,
    output logic [4:0]                   result_rd,
    output logic                         result_we,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]       occ_q;
    logic [DEPTH-1:0]       done_q;
    logic [DEPTH-1:0]       cmt_q;
    logic [DEPTH-1:0]       kill_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] fu_ptr_q, fu_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic             alloc_fire;
    logic             fu_hit;
    logic             fu_fire;
    logic             dup_id;
    logic [DEPTH-1:0] cmt_match;
    logic             alloc_cmt_match;
    logic             head_present;
    logic             head_drop;
    logic             pop;
    logic             retire;

    assign alloc_ready = (count_q != DEPTH_C);
    assign alloc_fire  = alloc_valid && alloc_ready;

    // The FU returns results in issue order, so only the oldest not-done entry can match.
    assign fu_hit  = occ_q[fu_ptr_q] && !done_q[fu_ptr_q] && (id_q[fu_ptr_q] == fu_id);
    assign fu_fire = fu_valid && fu_hit;

    // A commit arriving together with its own allocation must land on the new entry.
    assign alloc_cmt_match = commit_valid && (commit_id == alloc_id);

    always_comb begin
        dup_id    = 1'b0;
        cmt_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_q[i] && (id_q[i] == alloc_id)) begin
                dup_id = 1'b1;
            end
            cmt_match[i] = commit_valid && occ_q[i] && (id_q[i] == commit_id);
        end
    end

    // Head decode uses registered state only: no combinational path from the strobes or ready.
    assign head_present = occ_q[rd_ptr_q] && done_q[rd_ptr_q] && cmt_q[rd_ptr_q] && !kill_q[rd_ptr_q];
    assign head_drop    = occ_q[rd_ptr_q] && done_q[rd_ptr_q] && kill_q[rd_ptr_q];
    assign pop          = head_present && result_ready;
    assign retire       = pop || head_drop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fu_ptr_d = fu_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (alloc_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (fu_fire) begin
            fu_ptr_d = fu_ptr_q + PW'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if ((fu_valid && !fu_hit) || (alloc_fire && dup_id)) begin
            err_d = 1'b1;
        end
    end

    // Allocation never targets the head being retired: a free wr_ptr slot cannot be the occupied head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            occ_q    <= '0;
            done_q   <= '0;
            cmt_q    <= '0;
            kill_q   <= '0;
            wr_ptr_q <= '0;
            fu_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cmt_match[i]) begin
                    if (commit_kill) begin
                        kill_q[i] <= 1'b1;
                    end else begin
                        cmt_q[i] <= 1'b1;
                    end
                end
                if (fu_fire && (fu_ptr_q == PW'(i))) begin
                    data_q[i] <= fu_data;
                    done_q[i] <= 1'b1;
                end
                if (alloc_fire && (wr_ptr_q == PW'(i))) begin
                    occ_q[i]  <= 1'b1;
                    id_q[i]   <= alloc_id;
                    rd_q[i]   <= alloc_rd;
                    done_q[i] <= 1'b0;
                    cmt_q[i]  <= alloc_cmt_match && !commit_kill;
                    kill_q[i] <= alloc_cmt_match && commit_kill;
                end
                if (retire && (rd_ptr_q == PW'(i))) begin
                    occ_q[i]  <= 1'b0;
                    done_q[i] <= 1'b0;
                    cmt_q[i]  <= 1'b0;
                    kill_q[i] <= 1'b0;
                end
            end
            wr_ptr_q <= wr_ptr_d;
            fu_ptr_q <= fu_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign result_valid = head_present;
    assign result_we    = head_present;
    assign result_id    = head_present ? id_q[rd_ptr_q]   : '0;
    assign result_data  = head_present ? data_q[rd_ptr_q] : '0;
    assign result_rd    = head_present ? rd_q[rd_ptr_q]   : '0;
    assign count        = count_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_cv32e40x_xif_aes_result_queue.sv
// tb/tb_cv32e40x_xif_aes_result_queue.sv - directed self-checking bench for the AES result queue
module tb_cv32e40x_xif_aes_result_queue;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_id;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic        fu_valid;
    logic [3:0]  fu_id;
    logic [31:0] fu_data;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [2:0]  count;
    logic        protocol_err;

    int vectors;
    int miscompares;

    cv32e40x_xif_aes_result_queue #(
        .X_ID_WIDTH (4),
        .X_RFW_WIDTH(32),
        .DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_id    (alloc_id),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .fu_valid    (fu_valid),
        .fu_id       (fu_id),
        .fu_data     (fu_data),
        .commit_valid(commit_valid),
        .commit_id   (commit_id),
        .commit_kill (commit_kill),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_id   (result_id),
        .result_data (result_data),
        .result_rd   (result_rd),
        .result_we   (result_we),
        .count       (count),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic [4:0] rd);
        alloc_valid = 1'b1;
        alloc_id    = id;
        alloc_rd    = rd;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic do_fu(input logic [3:0] id, input logic [31:0] data);
        fu_valid = 1'b1;
        fu_id    = id;
        fu_data  = data;
        tick();
        fu_valid = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_id     = '0;
        alloc_rd     = '0;
        fu_valid     = 1'b0;
        fu_id        = '0;
        fu_data      = '0;
        commit_valid = 1'b0;
        commit_id    = '0;
        commit_kill  = 1'b0;
        result_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", result_valid, 0);
        chk("rst_we", result_we, 0);
        chk("rst_id", result_id, 0);
        chk("rst_data", result_data, 0);
        chk("rst_rd", result_rd, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_err", protocol_err, 0);
        rst_n = 1'b1;
        tick();

        // Single instruction: alloc, commit, FU result, held handshake, pop
        do_alloc(4'd3, 5'd5);
        chk("t1_count_alloc", count, 1);
        do_commit(4'd3, 1'b0);
        chk("t1_valid_before_fu", result_valid, 0);
        do_fu(4'd3, 32'hA5A5_0001);
        chk("t1_valid", result_valid, 1);
        chk("t1_we", result_we, 1);
        chk("t1_id", result_id, 3);
        chk("t1_rd", result_rd, 5);
        chk("t1_data", result_data, 32'hA5A5_0001);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_hold_valid", result_valid, 1);
            chk("t1_hold_id", result_id, 3);
            chk("t1_hold_rd", result_rd, 5);
            chk("t1_hold_data", result_data, 32'hA5A5_0001);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("t1_pop_count", count, 0);
        chk("t1_pop_valid", result_valid, 0);
        chk("t1_pop_data_zero", result_data, 0);

        // Fill to DEPTH, in-order drain, refill across the wrap
        do_alloc(4'd1, 5'd11);
        do_alloc(4'd2, 5'd12);
        do_alloc(4'd3, 5'd13);
        do_alloc(4'd4, 5'd14);
        chk("t2_full_ready", alloc_ready, 0);
        chk("t2_full_count", count, 4);
        do_alloc(4'd9, 5'd19);
        chk("t2_full_reject_count", count, 4);
        chk("t2_full_reject_err", protocol_err, 0);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b0);
        do_commit(4'd3, 1'b0);
        do_commit(4'd4, 1'b0);
        result_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            do_fu(4'(i), 32'h100 + 32'(i));
            chk("t2_valid", result_valid, 1);
            chk("t2_id", result_id, 32'(i));
            chk("t2_rd", result_rd, 32'(10 + i));
            chk("t2_data", result_data, 32'h100 + 32'(i));
            chk("t2_count", count, 32'(5 - i));
        end
        tick();
        chk("t2_drain_count", count, 0);
        chk("t2_drain_valid", result_valid, 0);
        do_alloc(4'd5, 5'd15);
        do_alloc(4'd6, 5'd16);
        do_commit(4'd5, 1'b0);
        do_commit(4'd6, 1'b0);
        do_fu(4'd5, 32'h0000_0555);
        chk("t2_wrap_id5", result_id, 5);
        chk("t2_wrap_data5", result_data, 32'h0000_0555);
        do_fu(4'd6, 32'h0000_0666);
        chk("t2_wrap_id6", result_id, 6);
        chk("t2_wrap_data6", result_data, 32'h0000_0666);
        tick();
        chk("t2_wrap_count", count, 0);

        // Kill drops silently, the next entry presents one cycle later
        do_alloc(4'd7, 5'd7);
        do_alloc(4'd8, 5'd8);
        do_commit(4'd7, 1'b1);
        do_commit(4'd8, 1'b0);
        do_fu(4'd7, 32'h0000_0077);
        chk("t3_killed_valid", result_valid, 0);
        chk("t3_killed_count", count, 2);
        do_fu(4'd8, 32'h0000_0088);
        chk("t3_next_valid", result_valid, 1);
        chk("t3_next_id", result_id, 8);
        chk("t3_next_data", result_data, 32'h0000_0088);
        chk("t3_next_count", count, 1);
        tick();
        chk("t3_drain_count", count, 0);
        chk("t3_err_clean", protocol_err, 0);
        result_ready = 1'b0;

        // Protocol errors: FU result with empty queue and with ID mismatch
        do_fu(4'd9, 32'hDEAD_0009);
        chk("t4_empty_err", protocol_err, 1);
        chk("t4_empty_count", count, 0);
        do_alloc(4'd2, 5'd2);
        do_fu(4'd9, 32'hDEAD_0019);
        chk("t4_mismatch_err", protocol_err, 1);
        chk("t4_mismatch_count", count, 1);
        chk("t4_mismatch_valid", result_valid, 0);
        do_commit(4'd2, 1'b0);
        chk("t4_not_done_valid", result_valid, 0);
        do_fu(4'd2, 32'h0000_0022);
        chk("t4_intact_id", result_id, 2);
        chk("t4_intact_data", result_data, 32'h0000_0022);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("t4_pop_count", count, 0);
        chk("t4_err_sticky", protocol_err, 1);

        // Commit in the allocation cycle, then asynchronous reset mid-queue
        alloc_valid  = 1'b1;
        alloc_id     = 4'd4;
        alloc_rd     = 5'd9;
        commit_valid = 1'b1;
        commit_id    = 4'd4;
        commit_kill  = 1'b0;
        tick();
        alloc_valid  = 1'b0;
        commit_valid = 1'b0;
        do_fu(4'd4, 32'hDEAD_BEEF);
        chk("t5_valid", result_valid, 1);
        chk("t5_id", result_id, 4);
        chk("t5_rd", result_rd, 9);
        chk("t5_data", result_data, 32'hDEAD_BEEF);
        do_alloc(4'd6, 5'd6);
        chk("t5_count", count, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", result_valid, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_err", protocol_err, 0);
        chk("t5_rst_ready", alloc_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_post_valid", result_valid, 0);
        chk("t5_post_count", count, 0);

        // Allocating an ID that is still occupied
        do_alloc(4'd1, 5'd1);
        chk("t6_first_err", protocol_err, 0);
        do_alloc(4'd1, 5'd2);
        chk("t6_dup_err", protocol_err, 1);
        chk("t6_dup_count", count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
